// File: rtl/mcp3008_cds_sampler.sv
// Correlated-double-sampling front end: reset/video conversion pair per pixel,
// clamped difference pushed into a small FIFO. Optional watchdog: CDS_WATCHDOG_EN.
module mcp3008_cds_sampler #(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_req,
    input  logic       vid_req,
    output logic       adc_sample,
    input  logic       adc_busy,
    input  logic [9:0] adc_data,
    input  logic       rd_en,
    output logic [9:0] rd_data,
    output logic       rd_valid,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       seq_err,
    output logic       tmo_err,
    input  logic       clr_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE, RST_REQ, RST_CONV, VID_WAIT, VID_REQ, VID_CONV, WRITE
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   busy_prev_q;
    logic                   busy_s, busy_rise, busy_fall;
    logic                   cap_rst, cap_vid, push;
    logic [9:0]             rst_lvl_q, vid_lvl_q;
    logic signed [10:0]     diff;
    logic [9:0]             pix;
    logic [9:0]             mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;
    logic                   push_ok, push_drop, pop, seq_ev;
    logic [9:0]             rd_data_q;
    logic                   rd_valid_q, overflow_q, seq_err_q;

    assign busy_s    = sync_q[SYNC_STAGES-1];
    assign busy_rise = busy_s & ~busy_prev_q;
    assign busy_fall = ~busy_s & busy_prev_q;

`ifdef CDS_WATCHDOG_EN
    logic [12:0] wd_cnt_q, wd_cnt_d;
    logic        wd_active, wd_expire, tmo_err_q;

    assign wd_active = (state_q == RST_REQ) || (state_q == RST_CONV) ||
                       (state_q == VID_REQ) || (state_q == VID_CONV);
    assign wd_expire = wd_active && (wd_cnt_q == 13'(TIMEOUT - 1));
    assign wd_cnt_d  = (state_d != state_q || !wd_active) ? 13'd0 : wd_cnt_q + 13'd1;
    assign tmo_err   = tmo_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^13'(TIMEOUT - 1);
    assign tmo_err        = 1'b0;
`endif

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        adc_sample = 1'b0;
        cap_rst    = 1'b0;
        cap_vid    = 1'b0;
        push       = 1'b0;
        case (state_q)
            IDLE:     if (pix_req) state_d = RST_REQ;
            RST_REQ: begin
                adc_sample = 1'b1;
                if (busy_rise) state_d = RST_CONV;
            end
            RST_CONV: if (busy_fall) begin
                cap_rst = 1'b1;
                state_d = VID_WAIT;
            end
            VID_WAIT: if (vid_req) state_d = VID_REQ;
            VID_REQ: begin
                adc_sample = 1'b1;
                if (busy_rise) state_d = VID_CONV;
            end
            VID_CONV: if (busy_fall) begin
                cap_vid = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
`ifdef CDS_WATCHDOG_EN
        if (wd_expire) begin
            state_d    = IDLE;
            adc_sample = 1'b0;
            cap_rst    = 1'b0;
            cap_vid    = 1'b0;
        end
`endif
    end

    // Negative differences clamp to zero; the positive range already fits 10 bits.
    assign diff = $signed({1'b0, rst_lvl_q}) - $signed({1'b0, vid_lvl_q});
    assign pix  = diff[10] ? 10'd0 : diff[9:0];

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = rd_en && !empty;
    assign push_ok   = push && (!full || rd_en);
    assign push_drop = push && full && !rd_en;
    assign seq_ev    = (pix_req && state_q != IDLE) || (vid_req && state_q != VID_WAIT);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            busy_prev_q <= 1'b0;
            rst_lvl_q   <= '0;
            vid_lvl_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], adc_busy};
            busy_prev_q <= busy_s;
            if (cap_rst) rst_lvl_q <= adc_data;
            if (cap_vid) vid_lvl_q <= adc_data;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            count_q    <= count_d;
            rd_valid_q <= pop;
            if (push_drop)    overflow_q <= 1'b1;
            else if (clr_err) overflow_q <= 1'b0;
            if (seq_ev)       seq_err_q  <= 1'b1;
            else if (clr_err) seq_err_q  <= 1'b0;
        end
    end

    // NOTE: storage array carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= pix;
    end

`ifdef CDS_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            if (wd_expire)    tmo_err_q <= 1'b1;
            else if (clr_err) tmo_err_q <= 1'b0;
        end
    end
`endif

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign overflow = overflow_q;
    assign seq_err  = seq_err_q;
endmodule

// File: doc/mcp3008_cds_sampler.md
# mcp3008_cds_sampler

Correlated-double-sampling front end for the CCD video chain. It sits directly upstream of the MCP3008 serial interface. Per pixel it requests two conversions: reset level, then video level. It subtracts the two and clamps the result, then buffers the pixel values in a small FIFO for the readout/USB side.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥ 2.
- SYNC_STAGES, 2: flops in the adc_busy synchronizer, ≥ 2.
- TIMEOUT, 4096: clk cycles allowed per conversion phase (only with the watchdog, see Configuration).
- clk  in  1  system clock; dclk to the ADC interface is derived from it.
- rst  in  1  synchronous, active-high reset.
- pix_req  in  1  one-cycle pulse: CCD at reset level, start a reset-level conversion.
- vid_req  in  1  one-cycle pulse: CCD at video level, start a video-level conversion.
- adc_sample  out  1  drives ADC interface sample.
- adc_busy  in  1  ADC interface busy; asynchronous to clk.
- adc_data  in  10  ADC interface 10-bit result; stable while adc_busy is low.
- rd_en  in  1  pop request.
- rd_data  out  10  popped pixel value.
- rd_valid  out  1  rd_data valid.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- overflow  out  1  sticky: a pixel was dropped.
- seq_err  out  1  sticky: a request arrived out of sequence.
- tmo_err  out  1  sticky: watchdog expired.
- clr_err  in  1  clears overflow, seq_err and tmo_err.

## Operation
- busy_s is adc_busy after SYNC_STAGES flops. busy_rise and busy_fall are single-cycle edges of busy_s.
- FSM states and transitions:
  - IDLE: on pix_req, go to RST_REQ.
  - RST_REQ: adc_sample=1. On busy_rise, go to RST_CONV.
  - RST_CONV: adc_sample=0. On busy_fall, rst_lvl<=adc_data and go to VID_WAIT.
  - VID_WAIT: on vid_req, go to VID_REQ.
  - VID_REQ: adc_sample=1. On busy_rise, go to VID_CONV.
  - VID_CONV: on busy_fall, vid_lvl<=adc_data and go to WRITE.
  - WRITE: push one entry and go to IDLE.
- Only a busy_rise edge releases a REQ state. busy_s already high on entry does not count; the FSM waits for it to fall and rise again.
- CDS arithmetic: pix = rst_lvl − vid_lvl, computed 11-bit signed. If negative, pix = 0. Otherwise pix is the low 10 bits; the maximum is 1023, so no upper clamp is needed.
- Push in WRITE:
  - If not full, the entry is written.
  - If full and rd_en is low, the pixel is dropped and overflow is set.
  - If full and rd_en is high the same cycle, both the pop and the push occur and the count is unchanged.
- Pop: rd_en with !empty reads the head entry. rd_en while empty is ignored and rd_valid stays 0.
- Pointers are log2(DEPTH) bits and wrap naturally. full and empty derive from a count register with range 0..DEPTH.
- pix_req outside IDLE, or vid_req outside VID_WAIT: the request is ignored, seq_err is set and the FSM is unaffected.
- clr_err in the same cycle as a new error event: the set wins.
- Reset values:
  - FSM = IDLE.
  - adc_sample, rd_valid, overflow, seq_err, tmo_err = 0.
  - rd_data, rst_lvl, vid_lvl = 0.
  - Pointers and count = 0.
  - empty = 1, full = 0.
  - Synchronizer flops = 0.
- Reset mid-conversion: all state is abandoned and adc_sample drops the next cycle. An ADC transaction still running completes without being captured.

## Timing
- pix_req or vid_req at cycle t: adc_sample is high at t+1.
- adc_sample stays high until the cycle after busy_rise is detected.
- Capture happens SYNC_STAGES+1 clk cycles after the adc_busy pin falls.
- WRITE occurs 1 cycle after the video capture. empty deasserts the cycle after WRITE.
- Pop: rd_en at cycle t gives rd_valid=1 and rd_data at t+1. rd_valid is a single-cycle pulse per pop.
- full and empty update the cycle after a push or pop. Back-to-back pops are supported at one entry per cycle.

## Configuration
- CDS_WATCHDOG_EN defined:
  - A 13-bit counter runs in RST_REQ, RST_CONV, VID_REQ and VID_CONV.
  - The counter clears on every state change.
  - When it reaches TIMEOUT−1: tmo_err is set, adc_sample goes to 0, the FSM returns to IDLE and no push occurs.
- CDS_WATCHDOG_EN undefined: no counter, the FSM waits indefinitely and tmo_err is tied to 0.

## Test plan
- Basic pixel:
  - Stimulus: pix_req; model returns 700; vid_req; model returns 200.
  - Response: one push; rd_en gives rd_data=500 and rd_valid=1 one cycle later; empty returns to 1.
- Clamp:
  - Stimulus: reset level 100, video level 300.
  - Response: rd_data=0.
  - Stimulus: reset level 1023, video level 0.
  - Response: rd_data=1023.
- Overflow:
  - Stimulus: 17 pixels with DEPTH=16 and no reads.
  - Response: full=1 after 16; overflow=1 after the 17th; reading 16 entries returns the first 16 values in order.
  - Stimulus: full FIFO, rd_en coincident with WRITE.
  - Response: no overflow, count stays 16.
- Sequence errors:
  - Stimulus: vid_req in IDLE.
  - Response: seq_err=1, no adc_sample.
  - Stimulus: pix_req in RST_CONV.
  - Response: seq_err=1, conversion unaffected.
  - Stimulus: clr_err.
  - Response: seq_err=0.
- Watchdog (CDS_WATCHDOG_EN):
  - Stimulus: adc_busy held low after pix_req.
  - Response: tmo_err=1 and adc_sample=0 TIMEOUT cycles after entering RST_REQ; FSM back in IDLE.
- Reset mid-operation:
  - Stimulus: rst asserted in VID_CONV.
  - Response: all outputs at reset values the next cycle; no push; a fresh pixel afterwards is processed correctly.
